dma_burst_gen: RTL and testbench

- Downstream of the DMA FSM and upstream of the DMA AXI interface. One instance per direction (read or write).
- Takes one descriptor (address, byte count) and splits it into AXI INCR burst requests. Each request carries addr/alen/size/strb.
- Requests obey the 4KB boundary, the max-beat limit and an outstanding-transaction cap.
- Unaligned head and partial tail bytes are issued as single-beat requests with a masked strobe, so each request carries exactly one strobe value.

---
 rtl/dma_burst_if.sv | 24 ++
 rtl/dma_burst_gen.sv | 158 +++++++++++++++
 tb/tb_dma_burst_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_burst_if.sv
// Request channel between the burst generator and the AXI-side engine:
// one burst request per valid/ready handshake, plus one completion pulse per finished request.
interface dma_burst_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0]   req_addr_o;
   logic [7:0]          req_alen_o;
   logic [2:0]          req_size_o;
   logic [DATA_W/8-1:0] req_strb_o;
   logic                req_valid_o;
   logic                req_ready_i;
   logic                txn_done_i;

   modport master (
      output req_addr_o, req_alen_o, req_size_o, req_strb_o, req_valid_o,
      input  req_ready_i, txn_done_i
   );

   modport slave (
      input  req_addr_o, req_alen_o, req_size_o, req_strb_o, req_valid_o,
      output req_ready_i, txn_done_i
   );
endinterface

// File: rtl/dma_burst_gen.sv
// Splits one (address, byte count) descriptor into AXI INCR burst requests that respect
// the 4KB page, the max-beat limit and a cap on outstanding requests.
module dma_burst_gen #(
   parameter int DATA_W         = 64,
   parameter int ADDR_W         = 32,
   parameter int BYTES_W        = 32,
   parameter int MAX_BEAT_BURST = 256,
   parameter int MAX_BURST_EN   = 1,
   parameter int MAX_OUTST      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [ADDR_W-1:0]            addr_i,
   input  logic [BYTES_W-1:0]           num_bytes_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(MAX_OUTST):0]   pend_o,
   dma_burst_if.master                  bus
);
   localparam int B  = DATA_W / 8;
   localparam int LB = $clog2(B);
   localparam int PW = $clog2(MAX_OUTST) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [BYTES_W-1:0] n;
      logic [7:0]         alen;
      logic [B-1:0]       strb;
   } req_t;

   // Head and tail pieces are single beats with a partial strobe; only aligned bodies burst.
   function automatic req_t calc_req(input logic [ADDR_W-1:0] addr, input logic [BYTES_W-1:0] rem);
      req_t               r;
      logic [LB-1:0]      off;
      logic [BYTES_W-1:0] room;
      logic [BYTES_W-LB-1:0] rem_beats;
      logic [13:0]        beats;
      logic [13:0]        page;
      r    = '0;
      off  = addr[LB-1:0];
      room = BYTES_W'(B) - BYTES_W'(off);
      rem_beats = rem[BYTES_W-1:LB];
      page  = (14'd4096 - {2'b00, addr[11:0]}) >> LB;
      beats = 14'd1;
      if (off != '0) begin
         r.n = (rem < room) ? rem : room;
         for (int i = 0; i < B; i++)
            r.strb[i] = (i >= int'(off)) && (i < int'(off) + int'(r.n));
      end else if (rem < BYTES_W'(B)) begin
         r.n = rem;
         for (int i = 0; i < B; i++)
            r.strb[i] = (i < int'(rem));
      end else begin
         if (rem_beats > (BYTES_W-LB)'(MAX_BEAT_BURST)) beats = 14'(MAX_BEAT_BURST);
         else beats = 14'(rem_beats);
         if (page < beats) beats = page;
         if (MAX_BURST_EN == 0) beats = 14'd1;
         r.alen = 8'(beats - 14'd1);
         r.strb = '1;
         r.n    = BYTES_W'(beats) << LB;
      end
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
   logic [BYTES_W-1:0] remaining_q, remaining_d;
   logic [PW-1:0]      pend_q, pend_d;
   logic               valid_q, valid_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [7:0]         alen_q, alen_d;
   logic [B-1:0]       strb_q, strb_d;
   logic [BYTES_W-1:0] n_q, n_d;
   logic               hs;
   req_t               nxt;

   assign hs = valid_q & bus.req_ready_i;

   // cur_addr/remaining describe the request currently presented; they advance on its handshake.
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      pend_d      = pend_q;
      valid_d     = valid_q;
      addr_d      = addr_q;
      alen_d      = alen_q;
      strb_d      = strb_q;
      n_d         = n_q;

      if (hs && !bus.txn_done_i)                       pend_d = pend_q + PW'(1);
      else if (!hs && bus.txn_done_i && pend_q != '0)  pend_d = pend_q - PW'(1);

      case (state_q)
         IDLE: if (start_i) begin
            cur_addr_d  = addr_i;
            remaining_d = num_bytes_i;
            state_d     = (num_bytes_i == '0) ? DONE : RUN;
         end
         RUN: begin
            if (hs) begin
               cur_addr_d  = cur_addr_q + ADDR_W'(n_q);
               remaining_d = remaining_q - n_q;
               valid_d     = 1'b0;
            end
            if (remaining_d == '0) state_d = DRAIN;
         end
         DRAIN: if (pend_q == '0) state_d = DONE;
         default: state_d = IDLE;
      endcase

      nxt = calc_req(cur_addr_d, remaining_d);
      if (state_d == RUN && !valid_d && remaining_d != '0 && pend_d < PW'(MAX_OUTST)) begin
         valid_d = 1'b1;
         addr_d  = {cur_addr_d[ADDR_W-1:LB], {LB{1'b0}}};
         alen_d  = nxt.alen;
         strb_d  = nxt.strb;
         n_d     = nxt.n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         pend_q      <= '0;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         alen_q      <= '0;
         strb_q      <= '0;
         n_q         <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         pend_q      <= pend_d;
         valid_q     <= valid_d;
         addr_q      <= addr_d;
         alen_q      <= alen_d;
         strb_q      <= strb_d;
         n_q         <= n_d;
      end
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(bus.txn_done_i && pend_q == '0));

   assign bus.req_valid_o = valid_q;
   assign bus.req_addr_o  = addr_q;
   assign bus.req_alen_o  = alen_q;
   assign bus.req_strb_o  = strb_q;
   assign bus.req_size_o  = 3'(LB);
   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == DONE);
   assign pend_o          = pend_q;
endmodule

// File: tb/tb_dma_burst_gen.sv
// Directed bench for dma_burst_gen: one bursting instance and one with bursts disabled (B = 8).
module tb_dma_burst_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0;
   logic [31:0] nb0 = '0, nb1 = '0;
   logic        busy0, done0, busy1, done1;
   logic [3:0]  pend0, pend1;
   logic        ready0 = 1'b1, auto0 = 1'b1, man_done0 = 1'b0;
   logic [1:0]  dly0, dly1;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] acc_addr [256];
   logic [7:0]  acc_alen [256];
   logic [7:0]  acc_strb [256];
   int          acc_cyc  [256];
   int          nacc = 0, ndone0 = 0, cyc = 0;
   int          cnt1 = 0, nz1 = 0, ndone1 = 0;

   dma_burst_if #(.DATA_W(64), .ADDR_W(32)) bus0 ();
   dma_burst_if #(.DATA_W(64), .ADDR_W(32)) bus1 ();

   dma_burst_gen dut0 (
      .clk(clk), .rst(rst), .start_i(start0), .addr_i(addr0), .num_bytes_i(nb0),
      .busy_o(busy0), .done_o(done0), .pend_o(pend0), .bus(bus0)
   );

   dma_burst_gen #(.MAX_BURST_EN(0)) dut1 (
      .clk(clk), .rst(rst), .start_i(start1), .addr_i(addr1), .num_bytes_i(nb1),
      .busy_o(busy1), .done_o(done1), .pend_o(pend1), .bus(bus1)
   );

   always #5 clk = ~clk;

   assign bus0.req_ready_i = ready0;
   assign bus0.txn_done_i  = auto0 ? dly0[1] : man_done0;
   assign bus1.req_ready_i = 1'b1;
   assign bus1.txn_done_i  = dly1[1];

   // Completions return two cycles after each accept.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dly0 <= '0;
         dly1 <= '0;
      end else begin
         dly0 <= {dly0[0], bus0.req_valid_o & bus0.req_ready_i};
         dly1 <= {dly1[0], bus1.req_valid_o & bus1.req_ready_i};
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus0.req_valid_o && bus0.req_ready_i) begin
         acc_addr[nacc & 255] <= bus0.req_addr_o;
         acc_alen[nacc & 255] <= bus0.req_alen_o;
         acc_strb[nacc & 255] <= bus0.req_strb_o;
         acc_cyc[nacc & 255]  <= cyc;
         nacc <= nacc + 1;
      end
      if (done0) ndone0 <= ndone0 + 1;
      if (bus1.req_valid_o) begin
         cnt1 <= cnt1 + 1;
         if (bus1.req_alen_o != 8'd0) nz1 <= nz1 + 1;
      end
      if (done1) ndone1 <= ndone1 + 1;
   end

   task automatic run_job(input logic [31:0] a, input logic [31:0] nb, input int wait_cyc);
      @(negedge clk); start0 = 1'b1; addr0 = a; nb0 = nb;
      @(negedge clk); start0 = 1'b0;
      repeat (wait_cyc) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if ({bus0.req_valid_o, busy0, done0} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got %b want 000", {bus0.req_valid_o, busy0, done0}); end
      n_cmp++; if ({bus0.req_addr_o, bus0.req_alen_o, bus0.req_strb_o} !== 48'h0) begin n_err++; $display("FAIL reset_req: got %h want 0", {bus0.req_addr_o, bus0.req_alen_o, bus0.req_strb_o}); end
      n_cmp++; if (pend0 !== 4'd0) begin n_err++; $display("FAIL reset_pend: got %0d want 0", pend0); end
      n_cmp++; if (bus0.req_size_o !== 3'd3) begin n_err++; $display("FAIL size: got %0d want 3", bus0.req_size_o); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int base = nacc; int db = ndone0;
      @(negedge clk); start0 = 1'b1; addr0 = 32'h1000; nb0 = 64;
      @(negedge clk); start0 = 1'b0;
      n_cmp++; if (bus0.req_valid_o !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", bus0.req_valid_o); end
      n_cmp++; if ({bus0.req_addr_o, bus0.req_alen_o, bus0.req_strb_o} !== {32'h1000, 8'd7, 8'hFF}) begin n_err++; $display("FAIL single_req: got %h want %h", {bus0.req_addr_o, bus0.req_alen_o, bus0.req_strb_o}, {32'h1000, 8'd7, 8'hFF}); end
      repeat (15) @(negedge clk);
      n_cmp++; if (nacc - base !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", nacc - base); end
      n_cmp++; if (ndone0 - db !== 1) begin n_err++; $display("FAIL single_done: got %0d want 1", ndone0 - db); end
      n_cmp++; if ({pend0, busy0} !== 5'd0) begin n_err++; $display("FAIL single_idle: got pend %0d busy %b want 0 0", pend0, busy0); end
   endtask

   task automatic test_unaligned();
      logic [31:0] ea [3] = '{32'h1000, 32'h1008, 32'h1000};
      logic [7:0]  es [3] = '{8'hF8, 8'h1F, 8'h1C};
      int base = nacc;
      run_job(32'h1003, 10, 12);
      run_job(32'h1002, 3, 12);
      n_cmp++; if (nacc - base !== 3) begin n_err++; $display("FAIL unal_count: got %0d want 3", nacc - base); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if ({acc_addr[(base+k)&255], acc_alen[(base+k)&255], acc_strb[(base+k)&255]} !== {ea[k], 8'd0, es[k]}) begin
            n_err++; $display("FAIL unal_req%0d: got %h want %h", k, {acc_addr[(base+k)&255], acc_alen[(base+k)&255], acc_strb[(base+k)&255]}, {ea[k], 8'd0, es[k]});
         end
      end
   endtask

   task automatic test_4k_and_max();
      logic [31:0] ea [4] = '{32'h0FF0, 32'h1000, 32'h0000, 32'h0800};
      logic [7:0]  el [4] = '{8'd1, 8'd5, 8'd255, 8'd255};
      int base = nacc;
      run_job(32'h0FF0, 64, 15);
      run_job(32'h0000, 4096, 15);
      n_cmp++; if (nacc - base !== 4) begin n_err++; $display("FAIL burst_count: got %0d want 4", nacc - base); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({acc_addr[(base+k)&255], acc_alen[(base+k)&255], acc_strb[(base+k)&255]} !== {ea[k], el[k], 8'hFF}) begin
            n_err++; $display("FAIL burst_req%0d: got %h want %h", k, {acc_addr[(base+k)&255], acc_alen[(base+k)&255], acc_strb[(base+k)&255]}, {ea[k], el[k], 8'hFF});
         end
      end
   endtask

   task automatic test_no_burst();
      @(negedge clk); start1 = 1'b1; addr1 = 32'h0; nb1 = 4096;
      @(negedge clk); start1 = 1'b0;
      repeat (600) @(negedge clk);
      n_cmp++; if (cnt1 !== 512) begin n_err++; $display("FAIL nb_count: got %0d want 512", cnt1); end
      n_cmp++; if (nz1 !== 0) begin n_err++; $display("FAIL nb_alen: got %0d nonzero want 0", nz1); end
      n_cmp++; if ({ndone1, busy1, pend1} !== {32'd1, 1'b0, 4'd0}) begin n_err++; $display("FAIL nb_done: got done %0d busy %b pend %0d want 1 0 0", ndone1, busy1, pend1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ea [3] = '{32'h4000, 32'h4008, 32'h4010};
      logic [7:0]  es [3] = '{8'hF0, 8'hFF, 8'h0F};
      int base = nacc; int db = ndone0;
      @(negedge clk); start0 = 1'b1; addr0 = 32'h4004; nb0 = 16;
      @(negedge clk); addr0 = 32'h9000; nb0 = 64;
      @(negedge clk); start0 = 1'b0;
      repeat (15) @(negedge clk);
      n_cmp++; if (nacc - base !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", nacc - base); end
      n_cmp++; if (ndone0 - db !== 1) begin n_err++; $display("FAIL b2b_done: got %0d want 1", ndone0 - db); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if ({acc_addr[(base+k)&255], acc_alen[(base+k)&255], acc_strb[(base+k)&255]} !== {ea[k], 8'd0, es[k]}) begin
            n_err++; $display("FAIL b2b_req%0d: got %h want %h", k, {acc_addr[(base+k)&255], acc_alen[(base+k)&255], acc_strb[(base+k)&255]}, {ea[k], 8'd0, es[k]});
         end
      end
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (acc_cyc[(base+k+1)&255] - acc_cyc[(base+k)&255] !== 1) begin
            n_err++; $display("FAIL b2b_gap%0d: got %0d want 1", k, acc_cyc[(base+k+1)&255] - acc_cyc[(base+k)&255]);
         end
      end
   endtask

   task automatic test_zero();
      int base = nacc;
      @(negedge clk); start0 = 1'b1; addr0 = 32'h5000; nb0 = 0;
      @(negedge clk); start0 = 1'b0;
      n_cmp++; if ({done0, busy0, bus0.req_valid_o} !== 3'b110) begin n_err++; $display("FAIL zero_done: got %b want 110", {done0, busy0, bus0.req_valid_o}); end
      @(negedge clk);
      n_cmp++; if ({done0, busy0} !== 2'b00) begin n_err++; $display("FAIL zero_idle: got %b want 00", {done0, busy0}); end
      n_cmp++; if (nacc - base !== 0) begin n_err++; $display("FAIL zero_count: got %0d want 0", nacc - base); end
   endtask

   task automatic test_outstanding_cap();
      int base;
      @(negedge clk); auto0 = 1'b0; ready0 = 1'b1; base = nacc;
      start0 = 1'b1; addr0 = 32'h0; nb0 = 32768;
      @(negedge clk); start0 = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++; if ({nacc - base, bus0.req_valid_o, pend0} !== {32'd8, 1'b0, 4'd8}) begin n_err++; $display("FAIL cap_full: got acc %0d valid %b pend %0d want 8 0 8", nacc - base, bus0.req_valid_o, pend0); end
      man_done0 = 1'b1;
      @(negedge clk); man_done0 = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++; if ({nacc - base, bus0.req_valid_o, pend0} !== {32'd9, 1'b0, 4'd8}) begin n_err++; $display("FAIL cap_one_more: got acc %0d valid %b pend %0d want 9 0 8", nacc - base, bus0.req_valid_o, pend0); end
      ready0 = 1'b0; man_done0 = 1'b1;
      @(negedge clk); man_done0 = 1'b0;
      n_cmp++; if ({bus0.req_valid_o, pend0} !== {1'b1, 4'd7}) begin n_err++; $display("FAIL cap_reopen: got valid %b pend %0d want 1 7", bus0.req_valid_o, pend0); end
      ready0 = 1'b1; man_done0 = 1'b1;
      @(negedge clk); ready0 = 1'b0; man_done0 = 1'b0;
      n_cmp++; if ({nacc - base, pend0} !== {32'd10, 4'd7}) begin n_err++; $display("FAIL cap_simul: got acc %0d pend %0d want 10 7", nacc - base, pend0); end
   endtask

   task automatic test_reset_mid_burst();
      int base; int db;
      n_cmp++; if (bus0.req_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", bus0.req_valid_o); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({bus0.req_valid_o, busy0, done0, pend0} !== 7'd0) begin n_err++; $display("FAIL mid_rst_ctrl: got %b want 0", {bus0.req_valid_o, busy0, done0, pend0}); end
      n_cmp++; if ({bus0.req_addr_o, bus0.req_alen_o, bus0.req_strb_o} !== 48'h0) begin n_err++; $display("FAIL mid_rst_req: got %h want 0", {bus0.req_addr_o, bus0.req_alen_o, bus0.req_strb_o}); end
      @(negedge clk); rst = 1'b0; auto0 = 1'b1; ready0 = 1'b1;
      base = nacc; db = ndone0;
      run_job(32'h2000, 16, 15);
      n_cmp++; if (nacc - base !== 1) begin n_err++; $display("FAIL post_rst_count: got %0d want 1", nacc - base); end
      n_cmp++; if ({acc_addr[base&255], acc_alen[base&255], acc_strb[base&255]} !== {32'h2000, 8'd1, 8'hFF}) begin n_err++; $display("FAIL post_rst_req: got %h want %h", {acc_addr[base&255], acc_alen[base&255], acc_strb[base&255]}, {32'h2000, 8'd1, 8'hFF}); end
      n_cmp++; if ({ndone0 - db, pend0} !== {32'd1, 4'd0}) begin n_err++; $display("FAIL post_rst_done: got done %0d pend %0d want 1 0", ndone0 - db, pend0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_unaligned();
      test_4k_and_max();
      test_no_burst();
      test_back_to_back();
      test_zero();
      test_outstanding_cap();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
